dcache_line_reader: RTL and testbench

//  Read-side engine for the 512x32 data-cache SRAM (simple dual-port, 1-cycle read latency, no output reg).
//  On a request it reads one whole cache line through the SRAM read port and streams the words out on a

---
 rtl/dcache_line_reader.sv | 175 +++++++++++++++++
 tb/tb_dcache_line_reader.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_line_reader.sv
// Line read engine for the data-cache SRAM: issues one line's word reads with credit
// limiting and streams the words out through a 2-entry output/skid buffer.
module dcache_line_reader #(
  parameter int ADDR_WIDTH      = 9,
  parameter int DATA_WIDTH      = 32,
  parameter int LINE_WORDS_LOG2 = 3,
  localparam int LW             = ADDR_WIDTH - LINE_WORDS_LOG2
) (
  input  logic                       rd_clk,
  input  logic                       rd_rst,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [LW-1:0]              req_line,
  output logic [ADDR_WIDTH-1:0]      sram_rd_addr,
  input  logic [DATA_WIDTH-1:0]      sram_rd_data,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [DATA_WIDTH-1:0]      m_data,
  output logic [LINE_WORDS_LOG2-1:0] m_word,
  output logic                       m_last,
  output logic                       busy,
  output logic                       done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [LINE_WORDS_LOG2-1:0] LAST_WORD = {LINE_WORDS_LOG2{1'b1}};

  state_t                     state_r;
  state_t                     state_s;
  logic [LW-1:0]              line_r;
  logic [LINE_WORDS_LOG2-1:0] issue_cnt_r;
  logic                       inflight_r;
  logic [LINE_WORDS_LOG2-1:0] cap_word_r;
  logic [ADDR_WIDTH-1:0]      addr_r;
  logic                       m_valid_r;
  logic [DATA_WIDTH-1:0]      m_data_r;
  logic [LINE_WORDS_LOG2-1:0] m_word_r;
  logic                       m_last_r;
  logic                       skid_valid_r;
  logic [DATA_WIDTH-1:0]      skid_data_r;
  logic [LINE_WORDS_LOG2-1:0] skid_word_r;
  logic                       skid_last_r;
  logic                       req_ready_r;
  logic                       busy_r;
  logic                       done_r;

  logic                       accept_s;
  logic                       pop_s;
  logic                       issue_s;
  logic                       last_issue_s;
  logic                       last_pop_s;
  logic                       cap_last_s;
  logic [2:0]                 credit_used_s;

  // State register
  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE:    if (accept_s) state_s = READ; else state_s = IDLE;
      READ:    if (last_issue_s) state_s = DRAIN; else state_s = READ;
      DRAIN:   if (last_pop_s) state_s = IDLE; else state_s = DRAIN;
      default: state_s = IDLE;
    endcase
  end

  // FSM control strobes; a word in flight plus buffered words may never exceed two
  always_comb begin
    accept_s      = (state_r == IDLE) && req_valid && req_ready_r;
    pop_s         = m_valid_r && m_ready;
    credit_used_s = {2'b00, m_valid_r} + {2'b00, skid_valid_r} + {2'b00, inflight_r};
    issue_s       = (state_r == READ) && (credit_used_s < (3'd2 + {2'b00, pop_s}));
    last_issue_s  = issue_s && (issue_cnt_r == LAST_WORD);
    last_pop_s    = pop_s && m_last_r;
    cap_last_s    = (cap_word_r == LAST_WORD);
  end

  // Request capture, read issue and status flags
  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      line_r      <= {LW{1'b0}};
      issue_cnt_r <= {LINE_WORDS_LOG2{1'b0}};
      inflight_r  <= 1'b0;
      cap_word_r  <= {LINE_WORDS_LOG2{1'b0}};
      addr_r      <= {ADDR_WIDTH{1'b0}};
      req_ready_r <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      req_ready_r <= (state_s == IDLE);
      busy_r      <= (state_s != IDLE);
      done_r      <= (state_r == DRAIN) && last_pop_s;
      inflight_r  <= issue_s;
      if (accept_s) begin
        line_r      <= req_line;
        issue_cnt_r <= {LINE_WORDS_LOG2{1'b0}};
        addr_r      <= {req_line, {LINE_WORDS_LOG2{1'b0}}};
      end else if (issue_s) begin
        issue_cnt_r <= issue_cnt_r + LINE_WORDS_LOG2'(1);
        cap_word_r  <= issue_cnt_r;
        // The address register presents the next word; it parks on the last word of the line
        if (!last_issue_s) begin
          addr_r <= {line_r, issue_cnt_r + LINE_WORDS_LOG2'(1)};
        end
      end
    end
  end

  // Output register with one skid entry behind it
  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      m_valid_r    <= 1'b0;
      m_data_r     <= {DATA_WIDTH{1'b0}};
      m_word_r     <= {LINE_WORDS_LOG2{1'b0}};
      m_last_r     <= 1'b0;
      skid_valid_r <= 1'b0;
      skid_data_r  <= {DATA_WIDTH{1'b0}};
      skid_word_r  <= {LINE_WORDS_LOG2{1'b0}};
      skid_last_r  <= 1'b0;
    end else if (pop_s) begin
      if (skid_valid_r) begin
        m_data_r     <= skid_data_r;
        m_word_r     <= skid_word_r;
        m_last_r     <= skid_last_r;
        skid_valid_r <= inflight_r;
        if (inflight_r) begin
          skid_data_r <= sram_rd_data;
          skid_word_r <= cap_word_r;
          skid_last_r <= cap_last_s;
        end
      end else if (inflight_r) begin
        m_data_r <= sram_rd_data;
        m_word_r <= cap_word_r;
        m_last_r <= cap_last_s;
      end else begin
        m_valid_r <= 1'b0;
      end
    end else if (inflight_r) begin
      if (!m_valid_r) begin
        m_valid_r <= 1'b1;
        m_data_r  <= sram_rd_data;
        m_word_r  <= cap_word_r;
        m_last_r  <= cap_last_s;
      end else begin
        skid_valid_r <= 1'b1;
        skid_data_r  <= sram_rd_data;
        skid_word_r  <= cap_word_r;
        skid_last_r  <= cap_last_s;
      end
    end
  end

  assign req_ready    = req_ready_r;
  assign sram_rd_addr = addr_r;
  assign m_valid      = m_valid_r;
  assign m_data       = m_data_r;
  assign m_word       = m_word_r;
  assign m_last       = m_last_r;
  assign busy         = busy_r;
  assign done         = done_r;

endmodule

// File: tb/tb_dcache_line_reader.sv
// Bench for dcache_line_reader: SRAM model, per-beat scoreboard, vector table of
// line/backpressure cases plus stall, reset-abort and back-to-back sequences.
module tb_dcache_line_reader;
  localparam int AW  = 9;
  localparam int DW  = 32;
  localparam int LWL = 3;
  localparam int LW  = 6;

  logic           clk = 1'b0;
  logic           rd_rst;
  logic           req_valid;
  logic           req_ready;
  logic [LW-1:0]  req_line;
  logic [AW-1:0]  sram_rd_addr;
  logic [DW-1:0]  sram_rd_data;
  logic           m_valid;
  logic           m_ready;
  logic [DW-1:0]  m_data;
  logic [LWL-1:0] m_word;
  logic           m_last;
  logic           busy;
  logic           done;

  logic [DW-1:0]  mem [0:511];

  always #5 clk = ~clk;

  always @(posedge clk) sram_rd_data <= mem[sram_rd_addr];

  dcache_line_reader dut (
    .rd_clk(clk), .rd_rst(rd_rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_line(req_line),
    .sram_rd_addr(sram_rd_addr), .sram_rd_data(sram_rd_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_word(m_word), .m_last(m_last),
    .busy(busy), .done(done)
  );

  typedef struct {
    logic [DW-1:0]  data;
    logic [LWL-1:0] word;
    logic           last;
  } beat_t;

  typedef struct {
    logic [LW-1:0] line;
    int            mode;      // 0 ready, 1 pattern 1,0,0, 2 random, 3 stall 20 then ready
    int            exp_first; // cycles from accept to first m_valid, -1 = unchecked
    int            exp_done;  // cycles from accept to done, -1 = unchecked
  } vec_t;

  beat_t          sb[$];
  vec_t           vecs[6];
  int             n_cmp = 0;
  int             n_fail = 0;
  int             cyc = 0;
  int             acc_cyc = 0;
  int             first_v_cyc = -1;
  int             done_cyc = 0;
  int             beats = 0;
  int             n_acc = 0;
  logic [LW-1:0]  cur_line = '0;
  bit             prev_stall = 1'b0;
  logic [DW-1:0]  prev_data = '0;
  logic [LWL-1:0] prev_word = '0;
  bit             done_seen = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic monitor();
    beat_t b;
    cyc++;
    if (rd_rst) begin
      prev_stall = 1'b0;
      return;
    end
    if (prev_stall) begin
      chk("stall_valid", {63'd0, m_valid}, 64'd1);
      chk("stall_data", {32'd0, m_data}, {32'd0, prev_data});
      chk("stall_word", {61'd0, m_word}, {61'd0, prev_word});
    end
    if (busy) chk("addr_in_line", {58'd0, sram_rd_addr[8:3]}, {58'd0, cur_line});
    if (done) begin
      done_seen = 1'b1;
      done_cyc  = cyc;
      chk("done_busy", {63'd0, busy}, 64'd0);
      chk("done_req_ready", {63'd0, req_ready}, 64'd1);
      chk("done_beats", beats, 8);
      chk("done_sb_empty", sb.size(), 0);
    end
    if (m_valid && m_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_beat", {32'd0, m_data}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        b = sb.pop_front();
        chk("beat_data", {32'd0, m_data}, {32'd0, b.data});
        chk("beat_word", {61'd0, m_word}, {61'd0, b.word});
        chk("beat_last", {63'd0, m_last}, {63'd0, b.last});
      end
      beats++;
    end
    if (req_valid && req_ready) begin
      for (int i = 0; i < 8; i++) begin
        sb.push_back('{mem[{req_line, 3'(i)}], 3'(i), (i == 7)});
      end
      cur_line    = req_line;
      acc_cyc     = cyc;
      first_v_cyc = -1;
      beats       = 0;
      done_seen   = 1'b0;
      n_acc++;
    end else if (m_valid && first_v_cyc < 0) begin
      first_v_cyc = cyc;
    end
    prev_stall = m_valid && !m_ready;
    prev_data  = m_data;
    prev_word  = m_word;
  endtask

  task automatic cycle();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic request(input logic [LW-1:0] line);
    int n0;
    n0 = n_acc;
    req_valid = 1'b1;
    req_line  = line;
    m_ready   = 1'b1;
    for (int t = 0; t < 50 && n_acc == n0; t++) cycle();
    req_valid = 1'b0;
    if (n_acc == n0) chk("accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic run_until_done(input int mode);
    int rel;
    for (int t = 0; t < 400 && !done_seen; t++) begin
      rel = cyc + 1 - acc_cyc;
      case (mode)
        0:       m_ready = 1'b1;
        1:       m_ready = ((rel - 1) % 3 == 0);
        2:       m_ready = 1'($urandom_range(0, 1));
        default: begin
          m_ready = (rel > 20);
          if (rel == 21) begin
            chk("stall_addr", {55'd0, sram_rd_addr}, {55'd0, cur_line, 3'd2});
            chk("stall_m_valid", {63'd0, m_valid}, 64'd1);
            chk("stall_m_word", {61'd0, m_word}, 64'd0);
            chk("stall_busy", {63'd0, busy}, 64'd1);
          end
        end
      endcase
      cycle();
    end
    if (!done_seen) chk("done_timeout", 64'd0, 64'd1);
    m_ready = 1'b1;
  endtask

  initial begin
    int a1;
    for (int a = 0; a < 512; a++) mem[a] = 32'h5A00_0000 | (a * 32'h0001_0003);
    for (int i = 0; i < 8; i++) mem[32'h40 + i] = 32'hA000_0000 + i;

    vecs[0] = '{6'd8,  0, 3, 11};
    vecs[1] = '{6'd8,  1, 3, -1};
    vecs[2] = '{6'd8,  3, 3, -1};
    vecs[3] = '{6'd63, 0, 3, 11};
    vecs[4] = '{6'd0,  2, 3, -1};
    vecs[5] = '{6'd21, 1, 3, -1};

    rd_rst = 1'b1; req_valid = 1'b0; req_line = '0; m_ready = 1'b0;
    @(posedge clk); #1;
    cycle(); cycle();
    chk("rst_req_ready", {63'd0, req_ready}, 64'd0);
    chk("rst_m_valid", {63'd0, m_valid}, 64'd0);
    chk("rst_m_data", {32'd0, m_data}, 64'd0);
    chk("rst_addr", {55'd0, sram_rd_addr}, 64'd0);
    chk("rst_busy_done", {62'd0, busy, done}, 64'd0);
    rd_rst = 1'b0;
    cycle();
    chk("post_rst_req_ready", {63'd0, req_ready}, 64'd1);

    for (int v = 0; v < 6; v++) begin
      request(vecs[v].line);
      run_until_done(vecs[v].mode);
      if (vecs[v].exp_first >= 0) chk("first_valid_lat", first_v_cyc - acc_cyc, vecs[v].exp_first);
      if (vecs[v].exp_done >= 0) chk("done_lat", done_cyc - acc_cyc, vecs[v].exp_done);
      cycle();
      cycle();
    end

    // reset after the 4th beat aborts the line
    request(6'd8);
    for (int t = 0; t < 50 && beats < 4; t++) cycle();
    rd_rst = 1'b1; m_ready = 1'b0;
    cycle();
    chk("abort_outputs", {58'd0, req_ready, m_valid, m_last, busy, done, 1'b0},  64'd0);
    chk("abort_data_word", {29'd0, m_word, m_data}, 64'd0);
    chk("abort_addr", {55'd0, sram_rd_addr}, 64'd0);
    rd_rst = 1'b0;
    sb.delete();
    cycle();
    chk("abort_req_ready", {63'd0, req_ready}, 64'd1);
    cycle();
    chk("abort_no_done", {63'd0, done_seen}, 64'd0);
    request(6'd1);
    run_until_done(0);
    chk("fresh_done_lat", done_cyc - acc_cyc, 11);
    cycle();

    // back-to-back requests with req_valid held high
    req_valid = 1'b1; req_line = 6'd2; m_ready = 1'b1;
    a1 = n_acc;
    for (int t = 0; t < 50 && n_acc == a1; t++) cycle();
    a1 = acc_cyc;
    req_line = 6'd3;
    for (int t = 0; t < 60 && cur_line != 6'd3; t++) cycle();
    chk("b2b_first_done_lat", done_cyc - a1, 11);
    chk("b2b_accept_gap", acc_cyc - a1, 11);
    req_valid = 1'b0;
    run_until_done(0);
    chk("b2b_second_done_lat", done_cyc - acc_cyc, 11);
    cycle();
    chk("final_sb_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
